alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle integer execution unit; successor to the single-cycle ALU in the execute stage.
- Adds width parameterisation and a valid/ready handshake on both sides.
- Adds a pipelined-latency multiplier, an iterative unsigned divider, a tag passthrough, an error flag and a flush.
- Sits between decode/issue and writeback. Issue holds the operation until `in_ready`; writeback consumes the result with `out_ready`.

Parameters:
- DATA_W, 32: operand/result width; must be ≥8 and a power of two.
- TAG_W, 5: width of the destination tag carried alongside the operation.
- MUL_LAT, 3: cycles from accept to `out_valid` for MUL/MULHU; must be ≥1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of any accepted, not-yet-consumed operation
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept this cycle
- op  input  4  operation code
- a  input  DATA_W  operand A
- b  input  DATA_W  operand B; low $clog2(DATA_W) bits are the shift amount for shifts
- tag  input  TAG_W  destination tag
- out_valid  output  1  result presented
- out_ready  input  1  consumer takes result this cycle
- result  output  DATA_W  result
- out_tag  output  TAG_W  tag of the accepted operation
- err  output  1  qualifies `result`: illegal op or divide-by-zero

Behaviour:
- Reset (async, rst=1): state=IDLE; `out_valid`=0, `result`=0, `out_tag`=0, `err`=0, counters 0. `in_ready` is 0 while rst is asserted.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT (signed), 6 SLTU (result 0/1, zero-extended)
  - 7 SLL, 8 SRL, 9 SRA
  - 10 MUL (low DATA_W of a*b), 11 MULHU (high DATA_W of unsigned a*b)
  - 12 DIVU, 13 REMU
  - 14–15 illegal
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W, no overflow flag.
- States: IDLE, BUSY, DONE.
- Accept rule: accept = in_valid & in_ready, where in_ready = (state==IDLE) | (state==DONE & out_ready).
- On accept, latch `tag` into `out_tag`, then branch by op:
  - Single-cycle ops: compute and register `result`/`err`; go to DONE. `out_valid`=1 the cycle after accept (latency 1).
  - MUL/MULHU: go to BUSY with counter=MUL_LAT-1; DONE entered MUL_LAT cycles after accept. MUL_LAT=1 behaves as a single-cycle op.
  - DIVU/REMU: restoring divider, one quotient bit per cycle. BUSY for DATA_W cycles; `out_valid` at accept+DATA_W+1.
  - Illegal op: result=0, err=1, latency 1.
- Divide by zero: no iteration, latency 1, err=1. DIVU returns all-ones; REMU returns `a`.
- DONE: `out_valid`=1; `result`, `out_tag` and `err` are held stable until out_ready=1. On out_ready: go to IDLE, or, if a new op is accepted in the same cycle, start it directly (back-to-back; no bubble for single-cycle ops).
- BUSY: in_ready=0; `out_valid`=0; operands held internally. Later changes on `a`/`b`/`op` are ignored.
- flush=1:
  - Next edge: state=IDLE, `out_valid`=0, `err`=0; an in-flight result is discarded.
  - `in_ready` is forced 0 during the flush cycle; flush has priority over accept and out_ready.
- Reset mid-operation: immediate return to reset values; no partial result is ever presented.
- `result`/`err` are don't-care when `out_valid`=0 but must be deterministic. They keep their last registered value.

Optional Feature:
- Macro ALU_MC_DIV_EN.
- Defined: DIVU/REMU use the iterative divider described above.
- Undefined: no divider logic is synthesised. Ops 12/13 are treated as illegal: result=0, err=1, latency 1.

Test Plan:
- Single-cycle ops, DATA_W=32, out_ready=1:
  - ADD a=0xFFFFFFFF, b=1 → result 0x00000000, err=0, out_valid one cycle after accept.
  - SRA a=0x80000000, b=4 → 0xF8000000.
  - SLT a=0xFFFFFFFF, b=0 → 1; SLTU same operands → 0.
- MUL/MULHU, MUL_LAT=3:
  - MUL a=0x10000, b=0x10000 → 0x00000000.
  - MULHU same operands → 0x00000001.
  - `out_valid` exactly 3 cycles after accept; in_ready=0 for the 2 intermediate cycles.
- Divider, ALU_MC_DIV_EN defined:
  - DIVU a=100, b=7 → 14; REMU a=100, b=7 → 2; out_valid at accept+33.
  - DIVU a=5, b=0 → 0xFFFFFFFF, err=1, latency 1.
  - Without the macro: DIVU → 0, err=1.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE → result/out_tag stable and in_ready=0.
  - Then assert out_ready with a new ADD pending → new op accepted in the same cycle; its result valid next cycle with its own tag.
- Flush: start DIVU, assert flush at cycle 10 of BUSY → next cycle IDLE, out_valid never asserts for that tag, in_ready=1.
- Async reset: assert rst between clock edges while in BUSY (MUL) → out_valid, result and err go 0 immediately. After release, the first op completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle integer execution unit with handshaked issue/writeback (divider under ALU_MC_DIV_EN)
module alu_mc #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [TAG_W-1:0]  tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              err
);

    localparam int SH_W    = $clog2(DATA_W);
    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [3:0]          op_q;
    logic [2*DATA_W-1:0] prod_q, prod_in;
    logic [DATA_W-1:0]   result_q, alu_res, busy_res;
    logic [TAG_W-1:0]    out_tag_q;
    logic                err_q, alu_err;
    logic                accept, is_mul, is_div, start_busy, last_busy;
    logic [SH_W-1:0]     shamt;

    assign shamt      = b[SH_W-1:0];
    assign accept     = in_valid & in_ready;
    assign is_mul     = (op == OP_MUL) | (op == OP_MULHU);
    assign start_busy = (is_mul & (MUL_LAT > 1)) | is_div;
    assign last_busy  = (state_q == BUSY) & (cnt_q == CNT_W'(1));
    assign prod_in    = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    assign result  = result_q;
    assign out_tag = out_tag_q;
    assign err     = err_q;

`ifdef ALU_MC_DIV_EN
    logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
    logic [DATA_W-1:0] rem_low, rem_diff, rem_nx, quo_nx;
    logic              rem_ge;

    // Zero divisors never iterate; they complete as a single-cycle op
    assign is_div = ((op == OP_DIVU) | (op == OP_REMU)) & (b != '0);

    // One restoring step: the shifted-out MSB of the partial remainder forces a subtract
    always_comb begin
        rem_low  = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        rem_ge   = rem_q[DATA_W-1] | (rem_low >= dvs_q);
        rem_diff = rem_low - dvs_q;
        rem_nx   = rem_ge ? rem_diff : rem_low;
        quo_nx   = {quo_q[DATA_W-2:0], rem_ge};
    end

    // Divider operand/partial registers, loaded on accept and stepped every BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (accept) begin
            quo_q <= a;
            rem_q <= '0;
            dvs_q <= b;
        end else if (state_q == BUSY) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end
`else
    assign is_div = 1'b0;
`endif

    // Single-cycle result, also covering divide-by-zero and illegal codes
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            OP_ADD:   alu_res = a + b;
            OP_SUB:   alu_res = a - b;
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = $signed(a) >>> shamt;
            OP_MUL:   alu_res = prod_in[DATA_W-1:0];
            OP_MULHU: alu_res = prod_in[2*DATA_W-1:DATA_W];
`ifdef ALU_MC_DIV_EN
            OP_DIVU: begin
                alu_res = '1;
                alu_err = (b == '0);
            end
            OP_REMU: begin
                alu_res = a;
                alu_err = (b == '0);
            end
`endif
            default:  alu_err = 1'b1;
        endcase
    end

    // Result produced at the end of a multi-cycle operation
    always_comb begin
        busy_res = (op_q == OP_MULHU) ? prod_q[2*DATA_W-1:DATA_W] : prod_q[DATA_W-1:0];
`ifdef ALU_MC_DIV_EN
        if (op_q == OP_DIVU) begin
            busy_res = quo_nx;
        end else if (op_q == OP_REMU) begin
            busy_res = rem_nx;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush beats accept, accept in DONE chains straight into the new op
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            BUSY:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = start_busy ? BUSY : DONE;
        end
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Handshake outputs derived from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = (state_q == DONE);
        if (!rst && !flush) begin
            in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        end
    end

    // Datapath registers: capture on accept, count down in BUSY, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
            err_q     <= 1'b0;
        end else if (flush) begin
            err_q <= 1'b0;
        end else if (accept) begin
            out_tag_q <= tag;
            op_q      <= op;
            prod_q    <= prod_in;
            cnt_q     <= is_div ? CNT_W'(DATA_W) : CNT_W'(MUL_LAT - 1);
            if (start_busy) begin
                err_q <= 1'b0;
            end else begin
                result_q <= alu_res;
                err_q    <= alu_err;
            end
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_busy) begin
                result_q <= busy_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc with a behavioural reference model
module tb_alu_mc;

    localparam int W       = 32;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = W + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]  tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [W-1:0] result;
    logic [4:0]  out_tag;
    logic        err;

    typedef struct {
        logic [W-1:0] r;
        logic         e;
        logic [4:0]   t;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   shown = 0;
    bit   rand_ready = 0;

    alu_mc #(.DATA_W(W), .TAG_W(5), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [4:0] t, input int c);
        exp_t            e;
        longint unsigned ux, uy, p;
        ux = x;
        uy = y;
        p  = ux * uy;
        e.r = '0; e.e = 1'b0; e.t = t; e.acc = c; e.lat = 1;
        case (o)
            4'd0: e.r = x + y;
            4'd1: e.r = x - y;
            4'd2: e.r = x & y;
            4'd3: e.r = x | y;
            4'd4: e.r = x ^ y;
            4'd5: e.r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd6: e.r = (x < y) ? 1 : 0;
            4'd7: e.r = x << y[4:0];
            4'd8: e.r = x >> y[4:0];
            4'd9: e.r = $signed(x) >>> y[4:0];
            4'd10: begin e.r = p[31:0];  e.lat = MUL_LAT; end
            4'd11: begin e.r = p[63:32]; e.lat = MUL_LAT; end
`ifdef ALU_MC_DIV_EN
            4'd12, 4'd13: begin
                if (y == 0) begin
                    e.r = (o == 4'd12) ? 32'hFFFF_FFFF : x;
                    e.e = 1'b1;
                end else begin
                    e.r = (o == 4'd12) ? x / y : x % y;
                    e.lat = DIV_LAT;
                end
            end
`endif
            default: e.e = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: pops on every completed handshake, pushes on every accept
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
            shown = 0;
        end else begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else if (out_valid) begin
                if (!shown) begin
                    check("latency", cyc - sb[0].acc, sb[0].lat);
                    shown = 1;
                end
                if (out_ready) begin
                    check("result", result, sb[0].r);
                    check("err", err, sb[0].e);
                    check("out_tag", out_tag, sb[0].t);
                    void'(sb.pop_front());
                    shown = 0;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(op, a, b, tag, cyc));
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [4:0] t);
        int n = 0;
        op = o; a = x; b = y; tag = t; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                check("issue_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            if (rand_ready) out_ready = $urandom_range(0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_ready) out_ready = $urandom_range(0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_out_tag", out_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
        drain();
        issue(4'd9, 32'h8000_0000, 32'd4, 5'd2);
        issue(4'd5, 32'hFFFF_FFFF, 32'd0, 5'd3);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 5'd4);
        drain();

        issue(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd5);
        @(negedge clk);
        check("mul_busy1_in_ready", in_ready, 0);
        check("mul_busy1_out_valid", out_valid, 0);
        @(negedge clk);
        check("mul_busy2_in_ready", in_ready, 0);
        @(posedge clk); #1;
        drain();
        issue(4'd11, 32'h0001_0000, 32'h0001_0000, 5'd6);
        drain();

        issue(4'd12, 32'd100, 32'd7, 5'd7);
        drain();
        issue(4'd13, 32'd100, 32'd7, 5'd8);
        drain();
        issue(4'd12, 32'd5, 32'd0, 5'd9);
        drain();
        issue(4'd15, 32'd1, 32'd2, 5'd10);
        drain();

        out_ready = 1'b0;
        issue(4'd0, 32'd3, 32'd4, 5'd11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 7);
            check("bp_out_tag", out_tag, 11);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'd0, 32'd10, 32'd20, 5'd12);
        drain();

        issue(4'd12, 32'd1000, 32'd3, 5'd13);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_out_valid", out_valid, 0);
        check("post_flush_in_ready", in_ready, 1);
        check("post_flush_err", err, 0);
        repeat (40) @(posedge clk);
        #1;

        issue(4'd0, 32'h55, 32'h22, 5'd14);
        drain();
        issue(4'd10, 32'd3, 32'd5, 5'd15);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_result", result, 0);
        check("async_rst_err", err, 0);
        check("async_rst_out_tag", out_tag, 0);
        check("async_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(4'd1, 32'd9, 32'd12, 5'd16);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            issue(ro, ra, rb, 5'($urandom_range(0, 31)));
        end
        rand_ready = 0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
